cdb_arbiter: RTL

- Shares the single common data bus (CDB) between the four functional units: int, mult, div and mem.
- Each unit's result enters a small per-unit queue. One result per cycle is granted, round-robin, and driven onto a registered CDB output that feeds the reservation stations and the ROB.
- Back-pressures each unit through a ready signal, so issue logic holds grants while a unit's queue is full.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: per-unit result requests with back-pressure, and the
// registered broadcast returned to reservation stations and the ROB.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 6
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ*TAG_W-1:0]  i_req_tag;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_cdb_valid;
  logic [TAG_W-1:0]          o_cdb_tag;
  logic [DATA_W-1:0]         o_cdb_data;
  logic [SRC_W-1:0]          o_cdb_src;
  logic                      o_drop;

  modport master (
    output i_req_valid, i_req_tag, i_req_data,
    input  o_req_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src, o_drop
  );

  modport slave (
    input  i_req_valid, i_req_tag, i_req_data,
    output o_req_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src, o_drop
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-unit result queues sharing one registered CDB, one grant per cycle.
// Define CDB_ARB_FIXED_PRIO_EN for fixed priority div > mult > mem > int instead of round-robin.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic          i_clk,
  input logic          i_rst_n,
  input logic          i_flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0]   buf_q [NUM_REQ][BUF_DEPTH];
  logic [CNT_W-1:0]   count [NUM_REQ];
  logic [PTR_W-1:0]   rptr  [NUM_REQ];
  logic [PTR_W-1:0]   wptr  [NUM_REQ];
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic               grant_any;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   scan_idx;
  logic [ENT_W-1:0]   win_entry;

  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [SRC_W-1:0]   cdb_src_q;
  logic               drop_q;

`ifdef CDB_ARB_FIXED_PRIO_EN
  localparam int unsigned PRIO [4] = '{2, 1, 3, 0};
`else
  logic [SRC_W-1:0]   rr_last;
`endif

  // Ready comes from the registered count only, so a full queue stays not-ready
  // even in the cycle it is popped.
  always_comb begin
    ready = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
      cand[i]  = (count[i] != '0) || bus.i_req_valid[i];
    end
  end

  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    scan_idx  = '0;
`ifdef CDB_ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = SRC_W'(PRIO[k]);
      if (!grant_any && cand[scan_idx]) begin
        grant_any = 1'b1;
        winner    = scan_idx;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = SRC_W'((32'(rr_last) + k) % NUM_REQ);
      if (!grant_any && cand[scan_idx]) begin
        grant_any = 1'b1;
        winner    = scan_idx;
      end
    end
`endif
  end

  // An empty winner is served straight from its inputs and never enters its queue.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pop[i]  = grant_any && (winner == SRC_W'(i)) && (count[i] != '0);
      push[i] = bus.i_req_valid[i] && ready[i] &&
                !(grant_any && (winner == SRC_W'(i)) && (count[i] == '0));
    end
    if (count[winner] != '0)
      win_entry = buf_q[winner][rptr[winner]];
    else
      win_entry = {bus.i_req_tag[winner*TAG_W +: TAG_W],
                   bus.i_req_data[winner*DATA_W +: DATA_W]};
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!i_flush && push[i])
        buf_q[i][wptr[i]] <= {bus.i_req_tag[i*TAG_W +: TAG_W],
                              bus.i_req_data[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        count[i] <= '0;
        rptr[i]  <= '0;
        wptr[i]  <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      drop_q      <= 1'b0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_last     <= SRC_W'(NUM_REQ - 1);
`endif
    end else begin
      if ((bus.i_req_valid & ~ready) != '0)
        drop_q <= 1'b1;
      if (i_flush) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          count[i] <= '0;
          rptr[i]  <= '0;
          wptr[i]  <= '0;
        end
        cdb_valid_q <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
          if (push[i])
            wptr[i] <= wptr[i] + PTR_W'(1);
          if (pop[i])
            rptr[i] <= rptr[i] + PTR_W'(1);
        end
        cdb_valid_q <= grant_any;
        if (grant_any) begin
          cdb_tag_q  <= win_entry[ENT_W-1 -: TAG_W];
          cdb_data_q <= win_entry[DATA_W-1:0];
          cdb_src_q  <= winner;
`ifndef CDB_ARB_FIXED_PRIO_EN
          rr_last    <= winner;
`endif
        end
      end
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_cdb_valid = cdb_valid_q;
  assign bus.o_cdb_tag   = cdb_tag_q;
  assign bus.o_cdb_data  = cdb_data_q;
  assign bus.o_cdb_src   = cdb_src_q;
  assign bus.o_drop      = drop_q;
endmodule
